// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead receive FIFO.
//
// Ports:
//   HCLK        in   system clock, all logic on its rising edge
//   HRESET      in   synchronous active-high reset
//   rx          in   asynchronous serial line, idles high
//   rd_en       in   pop the head byte (ignored while empty)
//   clr_err     in   clear frame_err and overflow (a same-cycle set wins)
//   rd_data     out  FIFO head byte, 0 while empty
//   empty       out  FIFO holds no bytes
//   full        out  FIFO holds 2**FIFO_AW bytes
//   count       out  exact FIFO occupancy
//   rx_done     out  one-cycle pulse after a good byte is pushed
//   frame_err   out  sticky, a stop bit sampled 0
//   overflow    out  sticky, a good byte was dropped on a full FIFO
//   dbg_state_o out  receiver FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// FIFO handshake: rd_data is valid whenever empty=0; a pop happens on the
// rising edge where rd_en=1 and empty=0, otherwise rd_en has no effect.
module uart_rx_fifo #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               rx,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               rx_done,
  output logic               frame_err,
  output logic               overflow,
  output logic [1:0]         dbg_state_o
);

  localparam int BCW = $clog2(CLK_DIV);
  localparam logic [BCW-1:0] BC_HALF = BCW'(CLK_DIV / 2 - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [2:0]       bi_q, bi_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sync1_q, rx_s_q, rx_prev_q;
  logic             start_edge, good_stop, bad_stop;
  logic             do_push, do_pop, ovf_set;
  logic             rx_done_q, frame_err_q, overflow_q;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [7:0]       mem [2**FIFO_AW];

  // The edge flop resets to 0, so a line held low through reset must be
  // seen high before any start edge can be recognised.
  assign start_edge = rx_prev_q & ~rx_s_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q   <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      bc_q    <= '0;
      bi_q    <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q + BCW'(1);
    bi_d      = bi_q;
    shreg_d   = shreg_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        bc_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        // Mid-start sample: a line already back high was only a glitch.
        if (bc_q == BC_HALF) begin
          bc_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bi_d    = '0;
          end
        end
      end
      DATA: begin
        if (bc_q == BC_FULL) begin
          bc_d          = '0;
          shreg_d[bi_q] = rx_s_q;
          if (bi_q == 3'd7) state_d = STOP;
          else              bi_d = bi_q + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (bc_q == BC_FULL) begin
          bc_d      = '0;
          state_d   = IDLE;
          good_stop = rx_s_q;
          bad_stop  = ~rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = rd_en & ~empty;
  assign do_push = good_stop & (~full | do_pop);
  assign ovf_set = good_stop & full & ~do_pop;

  always_ff @(posedge HCLK) begin
    if (do_push && !HRESET) mem[wptr_q] <= shreg_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (do_pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
      rx_done_q <= do_push;
      if (bad_stop)     frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
      if (ovf_set)      overflow_q  <= 1'b1;
      else if (clr_err) overflow_q  <= 1'b0;
    end
  end

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH);
  assign count       = count_q;
  assign rd_data     = empty ? 8'h00 : mem[rptr_q];
  assign rx_done     = rx_done_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with default parameters.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int BIT_T   = 16;
  localparam int PUSH_AT = 155;  // push edge relative to the edge before rx falls

  logic       HCLK = 1'b0;
  logic       HRESET, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, rx_done, frame_err, overflow;
  logic [4:0] count;
  logic [1:0] dbg_state;

  uart_rx_fifo dut (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .rx_done(rx_done), .frame_err(frame_err), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  typedef struct {
    int         edge_n;
    logic [7:0] data;
    bit         good;
  } frame_t;

  logic [7:0] exp_q[$];
  frame_t     pend_q[$];
  frame_t     cur_f;
  bit         exp_done, exp_ferr, exp_ovf;
  bit         m_pop, m_push, m_fe, m_oe;
  logic [7:0] m_data;

  always @(posedge HCLK) begin
    cyc++;
    if (HRESET) begin
      exp_q.delete();
      pend_q.delete();
      exp_done = 1'b0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      m_pop  = rd_en && (exp_q.size() > 0);
      m_push = 1'b0;
      m_fe   = 1'b0;
      m_oe   = 1'b0;
      m_data = 8'h00;
      if (pend_q.size() > 0 && pend_q[0].edge_n == cyc) begin
        cur_f = pend_q.pop_front();
        m_data = cur_f.data;
        if (!cur_f.good)                          m_fe = 1'b1;
        else if (exp_q.size() < DEPTH || m_pop)   m_push = 1'b1;
        else                                      m_oe = 1'b1;
      end
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_data);
      exp_done = m_push;
      if (m_fe)         exp_ferr = 1'b1;
      else if (clr_err) exp_ferr = 1'b0;
      if (m_oe)         exp_ovf = 1'b1;
      else if (clr_err) exp_ovf = 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("m_empty",   32'(empty),     32'(exp_q.size() == 0));
      chk("m_full",    32'(full),      32'(exp_q.size() == DEPTH));
      chk("m_count",   32'(count),     32'(exp_q.size()));
      chk("m_rd_data", 32'(rd_data),   (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
      chk("m_rx_done", 32'(rx_done),   32'(exp_done));
      chk("m_ferr",    32'(frame_err), 32'(exp_ferr));
      chk("m_ovf",     32'(overflow),  32'(exp_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge HCLK);
  endtask

  // Called at a negedge; the push edge is predicted from the current edge count.
  task automatic send_frame(input logic [7:0] d, input bit stop = 1'b1);
    frame_t f;
    f.edge_n = cyc + PUSH_AT;
    f.data   = d;
    f.good   = stop;
    pend_q.push_back(f);
    rx = 1'b0;
    tick(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BIT_T);
    end
    rx = stop;
    tick(BIT_T);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  int s;

  initial begin
    HRESET = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    chk_en = 1'b1;
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    HRESET = 1'b0;
    tick(4);

    // single 0x55 frame with exact latency
    s = cyc;
    fork
      send_frame(8'h55);
      begin
        wait_until(s + PUSH_AT - 1);
        chk("lat_before_empty", 32'(empty), 32'h1);
        tick();
        chk("lat_empty", 32'(empty), 32'h0);
        chk("lat_count", 32'(count), 32'h1);
        chk("lat_data", 32'(rd_data), 32'h55);
        chk("lat_done", 32'(rx_done), 32'h1);
        tick();
        chk("done_pulse_end", 32'(rx_done), 32'h0);
      end
    join
    tick(2);
    pop_one();
    chk("pop55_empty", 32'(empty), 32'h1);
    chk("pop55_count", 32'(count), 32'h0);

    // back-to-back frames
    send_frame(8'h41);
    send_frame(8'h42);
    send_frame(8'h43);
    tick(2);
    chk("b2b_count", 32'(count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_data", 32'(rd_data), 32'h41 + 32'(i));
      pop_one();
    end

    // 4-cycle glitch, then a real frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_idle", 32'(dbg_state), 32'h0);
    chk("glitch_count", 32'(count), 32'h0);
    send_frame(8'hA5);
    tick(2);
    chk("glitch_then_a5", 32'(rd_data), 32'hA5);
    pop_one();

    // framing error and clear
    send_frame(8'hA5, 1'b0);
    tick(4);
    chk("ferr_set", 32'(frame_err), 32'h1);
    chk("ferr_empty", 32'(empty), 32'h1);
    pulse_clr();
    chk("ferr_clr", 32'(frame_err), 32'h0);
    tick(4);

    // overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) send_frame(8'(i));
    tick(2);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_count", 32'(count), 32'h10);
    chk("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_pop_data", 32'(rd_data), 32'(i));
      pop_one();
    end
    pulse_clr();
    chk("ovf_clr", 32'(overflow), 32'h0);

    // full FIFO with a pop in the push cycle of 0x77
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i));
    s = cyc;
    fork
      send_frame(8'h77);
      begin
        wait_until(s + PUSH_AT - 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end
    join
    tick(2);
    chk("pp_count", 32'(count), 32'h10);
    chk("pp_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk("pp_data", 32'(rd_data), (i == 15) ? 32'h77 : 32'h21 + 32'(i));
      pop_one();
    end

    // reset in the middle of a frame
    s = cyc;
    fork
      send_frame(8'hF0);
      begin
        wait_until(s + 40);
        HRESET = 1'b1;
        tick(2);
        chk("midrst_empty", 32'(empty), 32'h1);
        chk("midrst_state", 32'(dbg_state), 32'h0);
        HRESET = 1'b0;
      end
    join
    tick(200);
    chk("midrst_nopush", 32'(count), 32'h0);

    // line low through and after reset
    HRESET = 1'b1;
    rx = 1'b0;
    tick(3);
    HRESET = 1'b0;
    tick(200);
    chk("lowrst_idle", 32'(dbg_state), 32'h0);
    chk("lowrst_count", 32'(count), 32'h0);
    chk("lowrst_ferr", 32'(frame_err), 32'h0);
    rx = 1'b1;
    tick(5);
    send_frame(8'h3C);
    tick(2);
    chk("lowrst_frame", 32'(rd_data), 32'h3C);
    chk("lowrst_cnt1", 32'(count), 32'h1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
